iru_ctrl: RTL and testbench
===========================

Name: iru_ctrl

Overview:
Job scheduler in front of the image rotation unit (IRU).
- Queues one-hot rotation decisions (36 angles) from the RNN together with a window tag.
- Issues each job to the IRU when the IRU is idle, then waits for completion.
- Presents the result to the BCAU and holds it until accepted.
- Drops malformed decisions and recovers from IRU hangs via a watchdog.

Parameters:
DEPTH, 4, job FIFO entries (power of 2, >=2)
TAG_W, 6, width of window tag carried with each job
TIMEOUT, 1024, max cycles in WAIT before the job is abandoned

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
rnn_valid  in  1  RNN presents a decision
rnn_ready  out  1  controller accepts decision this cycle
rnn_out  in  36  rotation decision, one-hot
rnn_tag  in  TAG_W  window id for the decision
iru_in_ready  in  1  IRU idle, may be started
iru_start  out  1  one-cycle start pulse to IRU (drives IRU rnn_out_ready)
iru_rot  out  36  rotation vector to IRU, stable from start until job ends
iru_out_ready  in  1  IRU result valid (level)
bcau_valid  out  1  rotated window available to BCAU
bcau_ready  in  1  BCAU accepts (bcau_in_ready)
bcau_tag  out  TAG_W  tag of the job being presented
busy  out  1  state != IDLE or FIFO non-empty
err_onehot  out  1  sticky: a non-one-hot decision was dropped
err_timeout  out  1  sticky: a job was abandoned by the watchdog
jobs_done  out  16  count of BCAU-accepted jobs, wraps at 2^16

Behaviour:
- Reset (sync, rst=1 at edge): FIFO flushed; state=IDLE; all outputs 0 (iru_rot=0, bcau_tag=0, counters 0, sticky flags 0). Reset mid-job abandons the job silently; no BCAU handshake is generated.
- Input handshake: rnn_ready = !full. Transfer occurs when rnn_valid && rnn_ready.
- Popcount check on transfer:
  - Exactly 1: push {rnn_out, rnn_tag}.
  - 0 or >=2: no push, err_onehot<=1.
- Full FIFO: ready is low, even if a pop occurs the same cycle (no push-through).
- FSM states:
  - IDLE:
    - If FIFO non-empty and iru_in_ready: pop; latch rot/tag into iru_rot/bcau_tag; iru_start=1 this cycle; next WAIT; watchdog<=0.
    - Else remain IDLE; iru_start=0.
  - WAIT:
    - iru_start=0; watchdog increments each cycle.
    - iru_out_ready is sampled only from the cycle after start onward.
    - If iru_out_ready=1: next HOLD.
    - Else if watchdog == TIMEOUT-1: err_timeout<=1; next IDLE; job discarded.
    - iru_out_ready and timeout in the same cycle: completion wins.
  - HOLD:
    - bcau_valid=1; iru_rot and bcau_tag remain stable.
    - If bcau_ready: jobs_done++; next IDLE, with bcau_valid=0 in the following cycle.
- Latency:
  - Push at edge N into an empty FIFO with IRU ready: iru_start high in cycle N+1.
  - iru_out_ready seen in cycle M: bcau_valid high from cycle M+1.
  - After BCAU acceptance: next iru_start at the earliest 2 cycles later (IDLE cycle then issue).
- FIFO push and pop in the same cycle (non-full): both occur, occupancy unchanged.
- Jobs are issued in FIFO order; tags are preserved unchanged.
- iru_rot is not cleared on return to IDLE; it keeps the last value.
- Sticky errors clear only on rst.

Test Plan:
- Single job: push rnn_out=36'h1<<5, tag=3, IRU responds iru_out_ready 20 cycles after start, bcau_ready=1 -> exactly one iru_start pulse, iru_rot=bit5, bcau_valid one cycle, bcau_tag=3, jobs_done=1.
- Backpressure: push 6 jobs back-to-back, iru_in_ready=0 -> rnn_ready low after 4 accepted. Release IRU -> tags issued 0,1,2,3, then remaining 4,5 accepted and issued in order.
- Malformed input: push rnn_out=0, then 36'h3, then 36'h10 -> err_onehot=1 after the first; only the third job is issued; jobs_done=1.
- Watchdog: TIMEOUT=16, iru_out_ready held 0 -> err_timeout=1 exactly 16 cycles after iru_start; bcau_valid never asserts; next queued job is issued afterwards.
- BCAU stall: bcau_ready=0 for 50 cycles -> bcau_valid, bcau_tag and iru_rot stable throughout; no new iru_start; acceptance increments jobs_done once.
- Reset mid-WAIT with 3 jobs queued: rst=1 for 1 cycle -> next cycle FIFO empty, busy=0, all outputs 0, no BCAU transfer.

Source files
------------

// File: rtl/iru_ctrl.sv
// iru_ctrl: job scheduler between RNN decisions, the IRU and the BCAU.
// Queues one-hot rotations with tags, issues to IRU, holds result to BCAU.
module iru_ctrl #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 6,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rnn_valid,
  output logic             rnn_ready,
  input  logic [35:0]      rnn_out,
  input  logic [TAG_W-1:0] rnn_tag,
  input  logic             iru_in_ready,
  output logic             iru_start,
  output logic [35:0]      iru_rot,
  input  logic             iru_out_ready,
  output logic             bcau_valid,
  input  logic             bcau_ready,
  output logic [TAG_W-1:0] bcau_tag,
  output logic             busy,
  output logic             err_onehot,
  output logic             err_timeout,
  output logic [15:0]      jobs_done
);

  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = AW + 1;
  localparam int WDW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HOLD
  } state_t;

  logic [35:0]      rot_mem [DEPTH];
  logic [TAG_W-1:0] tag_mem [DEPTH];

  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WDW-1:0]   wd_q;
  state_t           state_q;
  logic             start_q;
  logic             valid_q;
  logic [35:0]      rot_q;
  logic [TAG_W-1:0] tag_q;
  logic             eoh_q;
  logic             eto_q;
  logic [15:0]      done_q;

  logic full, empty, onehot, xfer, push, pop;

  assign full   = (cnt_q == CW'(DEPTH));
  assign empty  = (cnt_q == '0);
  assign onehot = (rnn_out != '0) &&
                  ((rnn_out & (rnn_out - 36'd1)) == '0);
  assign xfer   = rnn_valid && !full;
  assign push   = xfer && onehot;
  assign pop    = (state_q == IDLE) && !empty && iru_in_ready;

  assign wr_d  = push ? wr_q + AW'(1) : wr_q;
  assign rd_d  = pop ? rd_q + AW'(1) : rd_q;
  assign cnt_d = cnt_q + CW'(push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (push) begin
      rot_mem[wr_q] <= rnn_out;
      tag_mem[wr_q] <= rnn_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      wd_q    <= '0;
      state_q <= IDLE;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      rot_q   <= '0;
      tag_q   <= '0;
      eoh_q   <= 1'b0;
      eto_q   <= 1'b0;
      done_q  <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      start_q <= 1'b0;
      if (xfer && !onehot) eoh_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            rot_q   <= rot_mem[rd_q];
            tag_q   <= tag_mem[rd_q];
            start_q <= 1'b1;
            wd_q    <= '0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          wd_q <= wd_q + WDW'(1);
          // The start cycle itself is ignored: the IRU
          // cannot have answered a job it has not seen.
          if (!start_q && iru_out_ready) begin
            valid_q <= 1'b1;
            state_q <= HOLD;
          end else if (wd_q == WDW'(TIMEOUT - 1)) begin
            eto_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        HOLD: begin
          if (bcau_ready) begin
            valid_q <= 1'b0;
            done_q  <= done_q + 16'd1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rnn_ready   = !full;
  assign iru_start   = start_q;
  assign iru_rot     = rot_q;
  assign bcau_valid  = valid_q;
  assign bcau_tag    = tag_q;
  assign busy        = (state_q != IDLE) || !empty;
  assign err_onehot  = eoh_q;
  assign err_timeout = eto_q;
  assign jobs_done   = done_q;

endmodule

// File: tb/tb_iru_ctrl.sv
// tb_iru_ctrl: directed scenarios plus randomized run against a
// queue-based job model of the scheduler.
module tb_iru_ctrl;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [35:0] rot;
    logic [5:0]  tag;
  } job_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rnn_valid;
  logic [35:0] rnn_out;
  logic [5:0]  rnn_tag;
  logic        iru_in_ready;
  logic        iru_out_ready;
  logic        bcau_ready;

  logic        rnn_ready, iru_start, bcau_valid;
  logic        busy, err_onehot, err_timeout;
  logic [35:0] iru_rot;
  logic [5:0]  bcau_tag;
  logic [15:0] jobs_done;

  logic        w_rnn_ready, w_iru_start, w_bcau_valid;
  logic        w_busy, w_err_onehot, w_err_timeout;
  logic [35:0] w_iru_rot;
  logic [5:0]  w_bcau_tag;
  logic [15:0] w_jobs_done;

  int n_chk;
  int n_pass;
  int iru_cnt;
  int iru_lat;

  always #5 clk = ~clk;

  iru_ctrl #(.DEPTH(DEPTH), .TAG_W(6), .TIMEOUT(1024)) dut (
    .clk(clk), .rst(rst),
    .rnn_valid(rnn_valid), .rnn_ready(rnn_ready),
    .rnn_out(rnn_out), .rnn_tag(rnn_tag),
    .iru_in_ready(iru_in_ready), .iru_start(iru_start),
    .iru_rot(iru_rot), .iru_out_ready(iru_out_ready),
    .bcau_valid(bcau_valid), .bcau_ready(bcau_ready),
    .bcau_tag(bcau_tag), .busy(busy),
    .err_onehot(err_onehot), .err_timeout(err_timeout),
    .jobs_done(jobs_done)
  );

  iru_ctrl #(.DEPTH(DEPTH), .TAG_W(6), .TIMEOUT(16)) dut_wd (
    .clk(clk), .rst(rst),
    .rnn_valid(rnn_valid), .rnn_ready(w_rnn_ready),
    .rnn_out(rnn_out), .rnn_tag(rnn_tag),
    .iru_in_ready(iru_in_ready), .iru_start(w_iru_start),
    .iru_rot(w_iru_rot), .iru_out_ready(iru_out_ready),
    .bcau_valid(w_bcau_valid), .bcau_ready(bcau_ready),
    .bcau_tag(w_bcau_tag), .busy(w_busy),
    .err_onehot(w_err_onehot), .err_timeout(w_err_timeout),
    .jobs_done(w_jobs_done)
  );

  task automatic do_reset();
    rst = 1'b1;
    rnn_valid = 1'b0;
    rnn_out = '0;
    rnn_tag = '0;
    iru_in_ready = 1'b0;
    iru_out_ready = 1'b0;
    bcau_ready = 1'b0;
    iru_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Behavioural IRU: answers iru_lat cycles after a start.
  task automatic iru_step();
    if (iru_start) begin
      iru_cnt = iru_lat;
      iru_out_ready = 1'b0;
    end else if (iru_cnt > 0) begin
      iru_cnt--;
      if (iru_cnt == 0) iru_out_ready = 1'b1;
    end
    if (bcau_valid) iru_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if ({iru_start, bcau_valid, busy, err_onehot,
         err_timeout, rnn_ready} !== 6'b000001)
      $display("FAIL reset_flags got %b want 000001",
        {iru_start, bcau_valid, busy, err_onehot,
         err_timeout, rnn_ready});
    else n_pass++;
    n_chk++;
    if ({iru_rot, bcau_tag, jobs_done} !== '0)
      $display("FAIL reset_data got %h/%h/%h want 0",
        iru_rot, bcau_tag, jobs_done);
    else n_pass++;
  endtask

  task automatic test_single();
    int starts, vcyc, first_v;
    do_reset();
    iru_in_ready = 1'b1;
    bcau_ready = 1'b1;
    rnn_valid = 1'b1;
    rnn_out = 36'h1 << 5;
    rnn_tag = 6'd3;
    @(negedge clk);
    rnn_valid = 1'b0;
    n_chk++;
    if (iru_start !== 1'b0)
      $display("FAIL single_early got %b want 0", iru_start);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if ({iru_start, iru_rot, bcau_tag} !== {1'b1, 36'h20, 6'd3})
      $display("FAIL single_issue got %b %h %h want 1 20 3",
        iru_start, iru_rot, bcau_tag);
    else n_pass++;
    starts = 0;
    vcyc = 0;
    first_v = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (iru_start) starts++;
      if (bcau_valid) begin
        vcyc++;
        if (first_v < 0) first_v = i;
        n_chk++;
        if (bcau_tag !== 6'd3)
          $display("FAIL single_tag got %h want 3", bcau_tag);
        else n_pass++;
        iru_out_ready = 1'b0;
      end
      if (i == 20) iru_out_ready = 1'b1;
    end
    n_chk++;
    if (starts !== 0 || vcyc !== 1 || first_v !== 21)
      $display("FAIL single_seq got %0d/%0d/%0d want 0/1/21",
        starts, vcyc, first_v);
    else n_pass++;
    n_chk++;
    if ({jobs_done, iru_rot, busy} !== {16'd1, 36'h20, 1'b0})
      $display("FAIL single_end got %0d %h %b want 1 20 0",
        jobs_done, iru_rot, busy);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int acc, issued;
    logic [5:0] got [6];
    do_reset();
    bcau_ready = 1'b1;
    iru_lat = 3;
    acc = 0;
    issued = 0;
    for (int c = 0; c < 8; c++) begin
      rnn_valid = 1'b1;
      rnn_out = 36'h1 << acc;
      rnn_tag = 6'(acc);
      if (rnn_ready) acc++;
      @(negedge clk);
    end
    n_chk++;
    if (acc !== 4 || rnn_ready !== 1'b0 || busy !== 1'b1)
      $display("FAIL bp_full got acc=%0d rdy=%b want 4 0",
        acc, rnn_ready);
    else n_pass++;
    iru_in_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (iru_start) begin
        if (issued < 6) got[issued] = bcau_tag;
        issued++;
        n_chk++;
        if (iru_rot !== (36'h1 << bcau_tag))
          $display("FAIL bp_rot got %h tag %0d", iru_rot, bcau_tag);
        else n_pass++;
      end
      iru_step();
      if (acc < 6) begin
        rnn_valid = 1'b1;
        rnn_out = 36'h1 << acc;
        rnn_tag = 6'(acc);
        if (rnn_ready) acc++;
      end else begin
        rnn_valid = 1'b0;
      end
      @(negedge clk);
      if (issued >= 6 && !busy) break;
    end
    n_chk++;
    if (issued !== 6 || busy !== 1'b0)
      $display("FAIL bp_drain got issued=%0d busy=%b want 6 0",
        issued, busy);
    else n_pass++;
    for (int k = 0; k < 6; k++) begin
      n_chk++;
      if (k < issued && got[k] === 6'(k)) n_pass++;
      else $display("FAIL bp_order[%0d] got %h want %0d",
        k, got[k], k);
    end
    n_chk++;
    if (jobs_done !== 16'd6)
      $display("FAIL bp_done got %0d want 6", jobs_done);
    else n_pass++;
  endtask

  task automatic test_malformed();
    int starts;
    logic [5:0] st_tag;
    logic [35:0] st_rot;
    do_reset();
    iru_in_ready = 1'b1;
    bcau_ready = 1'b1;
    iru_lat = 2;
    rnn_valid = 1'b1;
    rnn_out = '0;
    rnn_tag = 6'd1;
    @(negedge clk);
    n_chk++;
    if (err_onehot !== 1'b1)
      $display("FAIL mal_zero got %b want 1", err_onehot);
    else n_pass++;
    rnn_out = 36'h3;
    rnn_tag = 6'd2;
    @(negedge clk);
    rnn_out = 36'h10;
    rnn_tag = 6'd3;
    @(negedge clk);
    rnn_valid = 1'b0;
    starts = 0;
    st_tag = '0;
    st_rot = '0;
    for (int i = 0; i < 30; i++) begin
      if (iru_start) begin
        starts++;
        st_tag = bcau_tag;
        st_rot = iru_rot;
      end
      iru_step();
      @(negedge clk);
    end
    n_chk++;
    if (starts !== 1 || st_tag !== 6'd3 || st_rot !== 36'h10)
      $display("FAIL mal_issue got %0d %h %h want 1 3 10",
        starts, st_tag, st_rot);
    else n_pass++;
    n_chk++;
    if ({jobs_done, err_onehot, err_timeout} !== {16'd1, 2'b10})
      $display("FAIL mal_end got %0d %b %b want 1 1 0",
        jobs_done, err_onehot, err_timeout);
    else n_pass++;
  endtask

  task automatic test_watchdog();
    int first_err, s2, vseen;
    logic [5:0] s2tag;
    logic [35:0] s2rot;
    do_reset();
    iru_in_ready = 1'b1;
    bcau_ready = 1'b1;
    rnn_valid = 1'b1;
    rnn_out = 36'h2;
    rnn_tag = 6'd7;
    @(negedge clk);
    rnn_out = 36'h4;
    rnn_tag = 6'd8;
    @(negedge clk);
    rnn_valid = 1'b0;
    n_chk++;
    if ({w_iru_start, w_bcau_tag} !== {1'b1, 6'd7})
      $display("FAIL wd_start got %b %h want 1 7",
        w_iru_start, w_bcau_tag);
    else n_pass++;
    first_err = -1;
    s2 = -1;
    vseen = 0;
    s2tag = '0;
    s2rot = '0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (w_err_timeout && first_err < 0) first_err = i;
      if (w_iru_start && s2 < 0) begin
        s2 = i;
        s2tag = w_bcau_tag;
        s2rot = w_iru_rot;
      end
      if (w_bcau_valid) vseen++;
    end
    n_chk++;
    if (first_err !== 16)
      $display("FAIL wd_err_cycle got %0d want 16", first_err);
    else n_pass++;
    n_chk++;
    if (s2 !== 17 || s2tag !== 6'd8 || s2rot !== 36'h4)
      $display("FAIL wd_next got %0d %h %h want 17 8 4",
        s2, s2tag, s2rot);
    else n_pass++;
    n_chk++;
    if (vseen !== 0 || w_jobs_done !== 16'd0)
      $display("FAIL wd_novalid got %0d %0d want 0 0",
        vseen, w_jobs_done);
    else n_pass++;
  endtask

  task automatic test_timeout_race();
    int first_v;
    do_reset();
    iru_in_ready = 1'b1;
    rnn_valid = 1'b1;
    rnn_out = 36'h1 << 30;
    rnn_tag = 6'd5;
    @(negedge clk);
    rnn_valid = 1'b0;
    @(negedge clk);
    first_v = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (w_bcau_valid && first_v < 0) first_v = i;
      if (i == 15) iru_out_ready = 1'b1;
    end
    n_chk++;
    if (first_v !== 16 || w_err_timeout !== 1'b0)
      $display("FAIL race got v=%0d to=%b want 16 0",
        first_v, w_err_timeout);
    else n_pass++;
    iru_out_ready = 1'b0;
    bcau_ready = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({w_jobs_done, w_bcau_valid} !== {16'd1, 1'b0})
      $display("FAIL race_accept got %0d %b want 1 0",
        w_jobs_done, w_bcau_valid);
    else n_pass++;
  endtask

  task automatic test_bcau_stall();
    int bad;
    do_reset();
    iru_in_ready = 1'b1;
    iru_lat = 2;
    rnn_valid = 1'b1;
    rnn_out = 36'h1 << 10;
    rnn_tag = 6'd9;
    @(negedge clk);
    rnn_out = 36'h1 << 20;
    rnn_tag = 6'd10;
    @(negedge clk);
    rnn_valid = 1'b0;
    for (int i = 0; i < 20 && !bcau_valid; i++) begin
      iru_step();
      @(negedge clk);
    end
    n_chk++;
    if (bcau_valid !== 1'b1)
      $display("FAIL stall_valid got %b want 1", bcau_valid);
    else n_pass++;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      iru_step();
      @(negedge clk);
      if (!bcau_valid || bcau_tag !== 6'd9 ||
          iru_rot !== (36'h1 << 10) || iru_start)
        bad++;
    end
    n_chk++;
    if (bad !== 0 || jobs_done !== 16'd0)
      $display("FAIL stall_hold got bad=%0d done=%0d want 0 0",
        bad, jobs_done);
    else n_pass++;
    bcau_ready = 1'b1;
    @(negedge clk);
    bcau_ready = 1'b0;
    n_chk++;
    if ({bcau_valid, iru_start, jobs_done} !== {2'b00, 16'd1})
      $display("FAIL stall_accept got %b %b %0d want 0 0 1",
        bcau_valid, iru_start, jobs_done);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if ({iru_start, bcau_tag, jobs_done} !== {1'b1, 6'd10, 16'd1})
      $display("FAIL stall_next got %b %h %0d want 1 a 1",
        iru_start, bcau_tag, jobs_done);
    else n_pass++;
  endtask

  task automatic test_reset_mid_wait();
    int starts, vseen;
    do_reset();
    iru_in_ready = 1'b1;
    bcau_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      rnn_valid = 1'b1;
      rnn_out = 36'h1 << k;
      rnn_tag = 6'(k);
      @(negedge clk);
    end
    rnn_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({busy, bcau_valid} !== 2'b10)
      $display("FAIL mid_wait got %b%b want 10", busy, bcau_valid);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_chk++;
    if ({iru_start, bcau_valid, busy, err_onehot,
         err_timeout, rnn_ready} !== 6'b000001)
      $display("FAIL mid_flags got %b want 000001",
        {iru_start, bcau_valid, busy, err_onehot,
         err_timeout, rnn_ready});
    else n_pass++;
    n_chk++;
    if ({iru_rot, bcau_tag, jobs_done} !== '0)
      $display("FAIL mid_data got %h/%h/%h want 0",
        iru_rot, bcau_tag, jobs_done);
    else n_pass++;
    iru_out_ready = 1'b1;
    starts = 0;
    vseen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (iru_start) starts++;
      if (bcau_valid) vseen++;
    end
    iru_out_ready = 1'b0;
    n_chk++;
    if (starts !== 0 || vseen !== 0 || jobs_done !== 16'd0)
      $display("FAIL mid_after got %0d %0d %0d want 0 0 0",
        starts, vseen, jobs_done);
    else n_pass++;
  endtask

  task automatic test_random();
    job_t q[$];
    job_t cur;
    job_t e;
    bit infl, exp_err, exp_start;
    bit exp_rdy, exp_busy;
    int exp_done;
    logic [63:0] r64;
    do_reset();
    infl = 1'b0;
    exp_err = 1'b0;
    exp_start = 1'b0;
    exp_done = 0;
    cur = '0;
    for (int c = 0; c < 3000; c++) begin
      n_chk++;
      if (iru_start !== exp_start)
        $display("FAIL rnd_start c=%0d got %b want %b",
          c, iru_start, exp_start);
      else n_pass++;
      if (iru_start && q.size() > 0) begin
        e = q.pop_front();
        cur = e;
        infl = 1'b1;
        n_chk++;
        if ({iru_rot, bcau_tag} !== e)
          $display("FAIL rnd_job c=%0d got %h %h want %h %h",
            c, iru_rot, bcau_tag, e.rot, e.tag);
        else n_pass++;
      end
      if (bcau_valid) begin
        n_chk++;
        if (!infl || {iru_rot, bcau_tag} !== cur)
          $display("FAIL rnd_hold c=%0d got %h %h want %h %h",
            c, iru_rot, bcau_tag, cur.rot, cur.tag);
        else n_pass++;
      end
      exp_rdy = (q.size() < DEPTH);
      exp_busy = (q.size() > 0) || infl;
      n_chk++;
      if ({rnn_ready, busy, err_onehot, err_timeout} !==
          {exp_rdy, exp_busy, exp_err, 1'b0})
        $display("FAIL rnd_flags c=%0d got %b%b%b%b want %b%b%b0",
          c, rnn_ready, busy, err_onehot, err_timeout,
          exp_rdy, exp_busy, exp_err);
      else n_pass++;
      n_chk++;
      if (jobs_done !== 16'(exp_done))
        $display("FAIL rnd_done c=%0d got %0d want %0d",
          c, jobs_done, 16'(exp_done));
      else n_pass++;
      iru_step();
      iru_lat = $urandom_range(1, 6);
      r64 = {$urandom, $urandom};
      rnn_valid = ($urandom_range(0, 1) != 0);
      if ($urandom_range(0, 4) != 0)
        rnn_out = 36'h1 << $urandom_range(0, 35);
      else
        rnn_out = r64[35:0];
      rnn_tag = 6'($urandom);
      iru_in_ready = ($urandom_range(0, 3) != 0);
      bcau_ready = ($urandom_range(0, 2) != 0);
      exp_start = !infl && (q.size() > 0) && iru_in_ready;
      if (rnn_valid && rnn_ready) begin
        if ($countones(rnn_out) == 1)
          q.push_back(job_t'({rnn_out, rnn_tag}));
        else
          exp_err = 1'b1;
      end
      if (bcau_valid && bcau_ready) begin
        exp_done++;
        infl = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    iru_cnt = 0;
    iru_lat = 2;
    test_reset();
    test_single();
    test_backpressure();
    test_malformed();
    test_watchdog();
    test_timeout_race();
    test_bcau_stall();
    test_reset_mid_wait();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

endmodule
